// File: rtl/execute_completion_monitor.sv
// Completion checker beside the execute stage: tracks issued tags against per-instruction deadlines.
// Define EXEC_MON_SQUASH_EN to let squash_valid/squash_mask drop mispredicted entries without error.
module execute_completion_monitor #(
    parameter int N        = 3,
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 16,
    parameter int MAX_LAT  = 8,
    parameter int TAG_W    = 6,
    parameter int BM_W     = 4,
    localparam int DL_W    = $clog2(MAX_LAT + 1),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             issue_valid,
    input  logic [NUM_CH-1:0][TAG_W-1:0]  issue_tag,
    input  logic [NUM_CH-1:0][DL_W-1:0]   issue_deadline,
    input  logic [NUM_CH-1:0][BM_W-1:0]   issue_bmask,
    input  logic [N-1:0]                  cdb_valid,
    input  logic [N-1:0][TAG_W-1:0]       cdb_tag,
    input  logic                          resolve_valid,
    input  logic [BM_W-1:0]               resolve_mask,
    input  logic                          squash_valid,
    input  logic [BM_W-1:0]               squash_mask,
    output logic                          err_timeout,
    output logic                          err_spurious,
    output logic                          err_dup,
    output logic                          err_overflow,
    output logic [2:0]                    first_err_code,
    output logic [TAG_W-1:0]              first_err_tag,
    output logic [CNT_W-1:0]              outstanding_cnt,
    output logic [31:0]                   completed_cnt
);
    localparam int AGE_W = $clog2(MAX_LAT + 2);
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(MAX_LAT + 1);

    logic [DEPTH-1:0]             ent_vld, nxt_vld;
    logic [DEPTH-1:0][TAG_W-1:0]  ent_tag, nxt_tag;
    logic [DEPTH-1:0][AGE_W-1:0]  ent_age, nxt_age;
    logic [DEPTH-1:0][AGE_W-1:0]  ent_dl,  nxt_dl;
    logic [DEPTH-1:0][BM_W-1:0]   ent_bm,  nxt_bm;

    logic [BM_W-1:0]   sq_m, rs_m;
    logic [NUM_CH-1:0] iss_live, iss_hit, iss_dup, iss_tmo, iss_ovf;
    logic [N-1:0]      lane_hit, lane_spur;
    logic [DEPTH-1:0]  ent_hit, ent_sq, ent_tmo, taken;
    logic [2:0]        det_code;
    logic [TAG_W-1:0]  det_tag;
    logic [CNT_W-1:0]  nxt_cnt;
    logic [31:0]       n_match;

`ifdef EXEC_MON_SQUASH_EN
    assign sq_m = squash_valid ? squash_mask : '0;
`else
    logic unused_squash;
    assign unused_squash = ^{squash_valid, squash_mask};
    assign sq_m = '0;
`endif
    assign rs_m = resolve_valid ? resolve_mask : '0;

    always_comb begin
        logic [AGE_W-1:0] age_inc;
        logic             found;
        age_inc  = '0;
        found    = 1'b0;
        iss_live = '0;
        iss_hit  = '0;
        iss_dup  = '0;
        iss_tmo  = '0;
        iss_ovf  = '0;
        lane_hit = '0;
        ent_hit  = '0;
        ent_sq   = '0;
        ent_tmo  = '0;
        taken    = '0;
        nxt_vld  = ent_vld;
        nxt_tag  = ent_tag;
        nxt_age  = ent_age;
        nxt_dl   = ent_dl;
        nxt_bm   = ent_bm;

        for (int c = 0; c < NUM_CH; c++)
            iss_live[c] = issue_valid[c] && ((issue_bmask[c] & sq_m) == '0);

        for (int l = 0; l < N; l++) begin
            if (cdb_valid[l]) begin
                for (int e = 0; e < DEPTH; e++)
                    if (ent_vld[e] && ent_tag[e] == cdb_tag[l]) begin
                        ent_hit[e]  = 1'b1;
                        lane_hit[l] = 1'b1;
                    end
                for (int c = 0; c < NUM_CH; c++)
                    if (iss_live[c] && issue_tag[c] == cdb_tag[l]) begin
                        iss_hit[c]  = 1'b1;
                        lane_hit[l] = 1'b1;
                    end
            end
        end
        lane_spur = cdb_valid & ~lane_hit;

        for (int c = 0; c < NUM_CH; c++) begin
            if (iss_live[c]) begin
                for (int e = 0; e < DEPTH; e++)
                    if (ent_vld[e] && ent_tag[e] == issue_tag[c]) iss_dup[c] = 1'b1;
                for (int k = 0; k < c; k++)
                    if (iss_live[k] && issue_tag[k] == issue_tag[c]) iss_dup[c] = 1'b1;
            end
        end

        // age_inc is the age during this cycle; deadline d allows completion up to d cycles after issue
        for (int e = 0; e < DEPTH; e++) begin
            age_inc    = (ent_age[e] == AGE_SAT) ? AGE_SAT : ent_age[e] + AGE_W'(1);
            ent_sq[e]  = ent_vld[e] && !ent_hit[e] && ((ent_bm[e] & sq_m) != '0);
            ent_tmo[e] = ent_vld[e] && !ent_hit[e] && !ent_sq[e] && (age_inc > ent_dl[e]);
            nxt_vld[e] = ent_vld[e] && !ent_hit[e] && !ent_sq[e] && !ent_tmo[e];
            nxt_age[e] = age_inc;
            nxt_bm[e]  = ent_bm[e] & ~rs_m;
        end

        // Only slots free at the start of the cycle are candidates
        for (int c = 0; c < NUM_CH; c++) begin
            if (iss_live[c] && !iss_dup[c] && !iss_hit[c]) begin
                if (issue_deadline[c] == '0) begin
                    iss_tmo[c] = 1'b1;
                end else begin
                    found = 1'b0;
                    for (int e = 0; e < DEPTH; e++)
                        if (!found && !ent_vld[e] && !taken[e]) begin
                            found      = 1'b1;
                            taken[e]   = 1'b1;
                            nxt_vld[e] = 1'b1;
                            nxt_tag[e] = issue_tag[c];
                            nxt_age[e] = '0;
                            nxt_dl[e]  = AGE_W'(issue_deadline[c]);
                            nxt_bm[e]  = issue_bmask[c] & ~rs_m;
                        end
                    iss_ovf[c] = !found;
                end
            end
        end

        // Scan high code/index first so the lowest code, then lowest index, is written last
        det_code = '0;
        det_tag  = '0;
        for (int c = NUM_CH-1; c >= 0; c--)
            if (iss_ovf[c]) begin det_code = 3'd4; det_tag = issue_tag[c]; end
        for (int c = NUM_CH-1; c >= 0; c--)
            if (iss_dup[c]) begin det_code = 3'd3; det_tag = issue_tag[c]; end
        for (int l = N-1; l >= 0; l--)
            if (lane_spur[l]) begin det_code = 3'd2; det_tag = cdb_tag[l]; end
        for (int c = NUM_CH-1; c >= 0; c--)
            if (iss_tmo[c]) begin det_code = 3'd1; det_tag = issue_tag[c]; end
        for (int e = DEPTH-1; e >= 0; e--)
            if (ent_tmo[e]) begin det_code = 3'd1; det_tag = ent_tag[e]; end

        nxt_cnt = '0;
        for (int e = 0; e < DEPTH; e++) nxt_cnt = nxt_cnt + CNT_W'(nxt_vld[e]);
        n_match = '0;
        for (int l = 0; l < N; l++) n_match = n_match + 32'(lane_hit[l]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_vld         <= '0;
            ent_tag         <= '0;
            ent_age         <= '0;
            ent_dl          <= '0;
            ent_bm          <= '0;
            err_timeout     <= 1'b0;
            err_spurious    <= 1'b0;
            err_dup         <= 1'b0;
            err_overflow    <= 1'b0;
            first_err_code  <= '0;
            first_err_tag   <= '0;
            outstanding_cnt <= '0;
            completed_cnt   <= '0;
        end else begin
            ent_vld         <= nxt_vld;
            ent_tag         <= nxt_tag;
            ent_age         <= nxt_age;
            ent_dl          <= nxt_dl;
            ent_bm          <= nxt_bm;
            err_timeout     <= err_timeout | (|iss_tmo) | (|ent_tmo);
            err_spurious    <= err_spurious | (|lane_spur);
            err_dup         <= err_dup | (|iss_dup);
            err_overflow    <= err_overflow | (|iss_ovf);
            if (first_err_code == '0 && det_code != '0) begin
                first_err_code <= det_code;
                first_err_tag  <= det_tag;
            end
            outstanding_cnt <= nxt_cnt;
            completed_cnt   <= completed_cnt + n_match;
        end
    end
endmodule

// File: tb/tb_execute_completion_monitor.sv
// Bench for execute_completion_monitor: directed scenarios plus randomized traffic against a
// cycle-stamped table model; honours EXEC_MON_SQUASH_EN the same way as the design.
module tb_execute_completion_monitor;
    localparam int N = 3, NUM_CH = 4, DEPTH = 16, MAX_LAT = 8, TAG_W = 6, BM_W = 4;
    localparam int DL_W = $clog2(MAX_LAT + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clock = 1'b0;
    logic reset;
    logic [NUM_CH-1:0]            issue_valid;
    logic [NUM_CH-1:0][TAG_W-1:0] issue_tag;
    logic [NUM_CH-1:0][DL_W-1:0]  issue_deadline;
    logic [NUM_CH-1:0][BM_W-1:0]  issue_bmask;
    logic [N-1:0]                 cdb_valid;
    logic [N-1:0][TAG_W-1:0]      cdb_tag;
    logic                         resolve_valid, squash_valid;
    logic [BM_W-1:0]              resolve_mask, squash_mask;
    logic err_timeout, err_spurious, err_dup, err_overflow;
    logic [2:0]       first_err_code;
    logic [TAG_W-1:0] first_err_tag;
    logic [CNT_W-1:0] outstanding_cnt;
    logic [31:0]      completed_cnt;

    execute_completion_monitor #(.N(N), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT),
                                 .TAG_W(TAG_W), .BM_W(BM_W)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_deadline(issue_deadline),
        .issue_bmask(issue_bmask), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .resolve_valid(resolve_valid), .resolve_mask(resolve_mask),
        .squash_valid(squash_valid), .squash_mask(squash_mask),
        .err_timeout(err_timeout), .err_spurious(err_spurious), .err_dup(err_dup),
        .err_overflow(err_overflow), .first_err_code(first_err_code),
        .first_err_tag(first_err_tag), .outstanding_cnt(outstanding_cnt),
        .completed_cnt(completed_cnt));

    always #5 clock = ~clock;

    // Model: each entry remembers the cycle it was issued in; age is simply now - born.
    typedef struct { bit v; int tag; int born; int dl; int bm; } ent_t;
    ent_t        tbl [DEPTH];
    int          cyc = 0;
    bit          m_to, m_sp, m_dup, m_ov;
    int          m_code, m_tag, m_out;
    int unsigned m_comp;
    int          best_code, best_ord, best_tag;
    int          n_pass = 0, n_tot = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic note(input int code, input int ord, input int tag);
        if (best_code == 0 || code < best_code || (code == best_code && ord < best_ord)) begin
            best_code = code; best_ord = ord; best_tag = tag;
        end
    endtask

    task automatic model_step();
        int  it[NUM_CH], idl[NUM_CH], ibm[NUM_CH], ct[N];
        bit  live[NUM_CH], dup[NUM_CH], ihit[NUM_CH], ehit[DEPTH], was_v[DEPTH];
        int  sqm, rsm, idx;
        bit  hit;
        int  freeq[$];
        cyc++;
        if (reset) begin
            foreach (tbl[e]) tbl[e].v = 0;
            {m_to, m_sp, m_dup, m_ov} = '0;
            m_code = 0; m_tag = 0; m_out = 0; m_comp = 0;
            return;
        end
        sqm = 0;
`ifdef EXEC_MON_SQUASH_EN
        if (squash_valid) sqm = int'(squash_mask);
`endif
        rsm = resolve_valid ? int'(resolve_mask) : 0;
        best_code = 0; best_ord = 0; best_tag = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            it[c] = int'(issue_tag[c]); idl[c] = int'(issue_deadline[c]); ibm[c] = int'(issue_bmask[c]);
            live[c] = issue_valid[c] && ((ibm[c] & sqm) == 0);
            ihit[c] = 0; dup[c] = 0;
        end
        for (int e = 0; e < DEPTH; e++) begin was_v[e] = tbl[e].v; ehit[e] = 0; end
        for (int l = 0; l < N; l++) begin
            ct[l] = int'(cdb_tag[l]);
            if (cdb_valid[l]) begin
                hit = 0;
                for (int e = 0; e < DEPTH; e++)
                    if (tbl[e].v && tbl[e].tag == ct[l]) begin ehit[e] = 1; hit = 1; end
                for (int c = 0; c < NUM_CH; c++)
                    if (live[c] && it[c] == ct[l]) begin ihit[c] = 1; hit = 1; end
                if (hit) m_comp++;
                else begin m_sp = 1; note(2, l, ct[l]); end
            end
        end
        for (int c = 0; c < NUM_CH; c++) if (live[c]) begin
            for (int e = 0; e < DEPTH; e++) if (tbl[e].v && tbl[e].tag == it[c]) dup[c] = 1;
            for (int k = 0; k < c; k++) if (live[k] && it[k] == it[c]) dup[c] = 1;
            if (dup[c]) begin m_dup = 1; note(3, c, it[c]); end
        end
        for (int e = 0; e < DEPTH; e++) if (tbl[e].v) begin
            if (ehit[e] || (tbl[e].bm & sqm) != 0) tbl[e].v = 0;
            else if (cyc - tbl[e].born > tbl[e].dl) begin
                tbl[e].v = 0; m_to = 1; note(1, e, tbl[e].tag);
            end else tbl[e].bm = tbl[e].bm & ~rsm;
        end
        for (int e = 0; e < DEPTH; e++) if (!was_v[e]) freeq.push_back(e);
        for (int c = 0; c < NUM_CH; c++) if (live[c] && !dup[c] && !ihit[c]) begin
            if (idl[c] == 0) begin m_to = 1; note(1, DEPTH + c, it[c]); end
            else if (freeq.size() > 0) begin
                idx = freeq.pop_front();
                tbl[idx].v = 1; tbl[idx].tag = it[c]; tbl[idx].born = cyc;
                tbl[idx].dl = idl[c]; tbl[idx].bm = ibm[c] & ~rsm;
            end else begin m_ov = 1; note(4, c, it[c]); end
        end
        if (m_code == 0 && best_code != 0) begin m_code = best_code; m_tag = best_tag; end
        m_out = 0;
        foreach (tbl[e]) if (tbl[e].v) m_out++;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("err_timeout", 64'(err_timeout), 64'(m_to));
            chk("err_spurious", 64'(err_spurious), 64'(m_sp));
            chk("err_dup", 64'(err_dup), 64'(m_dup));
            chk("err_overflow", 64'(err_overflow), 64'(m_ov));
            chk("first_err_code", 64'(first_err_code), 64'(m_code));
            chk("first_err_tag", 64'(first_err_tag), 64'(m_tag));
            chk("outstanding_cnt", 64'(outstanding_cnt), 64'(m_out));
            chk("completed_cnt", 64'(completed_cnt), 64'(m_comp));
        end
    end

    task automatic clear_in();
        issue_valid = '0; issue_tag = '0; issue_deadline = '0; issue_bmask = '0;
        cdb_valid = '0; cdb_tag = '0;
        resolve_valid = 1'b0; resolve_mask = '0; squash_valid = 1'b0; squash_mask = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        clear_in(); reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic issue(input int c, input int tag, input int dl, input int bm);
        issue_valid[c] = 1'b1; issue_tag[c] = TAG_W'(tag);
        issue_deadline[c] = DL_W'(dl); issue_bmask[c] = BM_W'(bm);
    endtask

    task automatic cdb(input int l, input int tag);
        cdb_valid[l] = 1'b1; cdb_tag[l] = TAG_W'(tag);
    endtask

    task automatic rand_inputs();
        int pool[$];
        foreach (tbl[e]) if (tbl[e].v) pool.push_back(tbl[e].tag);
        clear_in();
        for (int c = 0; c < NUM_CH; c++) begin
            issue_valid[c]    = ($urandom_range(99) < 35);
            issue_tag[c]      = TAG_W'($urandom_range(31));
            issue_deadline[c] = DL_W'($urandom_range(MAX_LAT));
            issue_bmask[c]    = BM_W'($urandom);
        end
        for (int l = 0; l < N; l++) begin
            cdb_valid[l] = ($urandom_range(99) < 40);
            if (pool.size() > 0 && $urandom_range(99) < 80)
                cdb_tag[l] = TAG_W'(pool[$urandom_range(pool.size() - 1)]);
            else
                cdb_tag[l] = TAG_W'($urandom_range(31));
            for (int k = 0; k < l; k++) if (cdb_valid[k] && cdb_tag[k] == cdb_tag[l]) cdb_valid[l] = 1'b0;
        end
        resolve_valid = ($urandom_range(9) == 0); resolve_mask = BM_W'($urandom);
        squash_valid  = ($urandom_range(9) == 0); squash_mask  = BM_W'($urandom);
        reset = ($urandom_range(149) == 0);
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_flags", 64'({err_timeout, err_spurious, err_dup, err_overflow}), 64'(0));
        chk("rst_code", 64'(first_err_code), 64'(0));
        chk("rst_out", 64'(outstanding_cnt), 64'(0));
        chk("rst_comp", 64'(completed_cnt), 64'(0));
        reset = 1'b0;

        issue(0, 5, 0, 0); cdb(0, 5); tick(); clear_in();
        chk("bypass_comp", 64'(completed_cnt), 64'(1));
        chk("bypass_out", 64'(outstanding_cnt), 64'(0));
        chk("bypass_flags", 64'({err_timeout, err_spurious, err_dup, err_overflow}), 64'(0));

        do_reset();
        issue(1, 9, 4, 0); tick(); clear_in();
        chk("mult_out", 64'(outstanding_cnt), 64'(1));
        repeat (3) tick();
        cdb(0, 9); tick(); clear_in();
        chk("mult_ok_flags", 64'({err_timeout, err_spurious, err_dup, err_overflow}), 64'(0));
        chk("mult_ok_comp", 64'(completed_cnt), 64'(1));
        issue(1, 9, 4, 0); tick(); clear_in();
        repeat (4) tick();
        chk("tmo_early", 64'(err_timeout), 64'(0));
        tick();
        chk("tmo_flag", 64'(err_timeout), 64'(1));
        chk("tmo_code", 64'(first_err_code), 64'(1));
        chk("tmo_tag", 64'(first_err_tag), 64'(9));
        chk("tmo_out", 64'(outstanding_cnt), 64'(0));

        do_reset();
        cdb(1, 12); tick(); clear_in();
        chk("spur_flag", 64'(err_spurious), 64'(1));
        chk("spur_code", 64'(first_err_code), 64'(2));
        chk("spur_tag", 64'(first_err_tag), 64'(12));

        do_reset();
        issue(0, 3, 5, 0); issue(2, 3, 5, 0); tick(); clear_in();
        chk("dup_flag", 64'(err_dup), 64'(1));
        chk("dup_out", 64'(outstanding_cnt), 64'(1));
        chk("dup_code", 64'(first_err_code), 64'(3));

        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < NUM_CH; c++) issue(c, 4 * k + c, 8, 0);
            tick(); clear_in();
        end
        chk("full_out", 64'(outstanding_cnt), 64'(16));
        issue(0, 20, 8, 0); tick(); clear_in();
        chk("ovf_flag", 64'(err_overflow), 64'(1));
        chk("ovf_out", 64'(outstanding_cnt), 64'(16));
        chk("ovf_code", 64'(first_err_code), 64'(4));
        chk("ovf_tag", 64'(first_err_tag), 64'(20));
        cdb(0, 0); issue(0, 21, 8, 0); tick(); clear_in();
        chk("full_free_out", 64'(outstanding_cnt), 64'(15));
        chk("full_free_comp", 64'(completed_cnt), 64'(1));

        do_reset();
        issue(0, 7, 8, 2); issue(1, 8, 8, 1); tick(); clear_in();
        squash_valid = 1'b1; squash_mask = 4'b0010; tick(); clear_in();
`ifdef EXEC_MON_SQUASH_EN
        chk("squash_out", 64'(outstanding_cnt), 64'(1));
        chk("squash_flags", 64'({err_timeout, err_spurious, err_dup, err_overflow}), 64'(0));
`else
        chk("nosquash_out", 64'(outstanding_cnt), 64'(2));
        repeat (7) tick();
        chk("nosquash_early", 64'(err_timeout), 64'(0));
        tick();
        chk("nosquash_tmo", 64'(err_timeout), 64'(1));
        chk("nosquash_tag", 64'(first_err_tag), 64'(7));
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end
        clear_in(); reset = 1'b0; tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/execute_completion_monitor.md
# execute_completion_monitor

Parametrised, synthesizable completion checker that sits beside the execute stage. It watches every functional-unit issue channel and every CDB lane, and tracks each issued destination tag in an outstanding table with a per-instruction deadline. It raises sticky error flags for a missed deadline, a spurious CDB broadcast, a duplicate in-flight tag or table overflow. This replaces the fixed-shape execute assertion harness with one block that covers any N, FU mix and latency profile.

## Interface
- `N`, 3 — CDB lanes
- `NUM_CH`, 4 — issue channels (ALU + MULT + BRANCH + LDST, flattened)
- `DEPTH`, 16 — outstanding-table entries
- `MAX_LAT`, 8 — largest legal deadline in cycles
- `TAG_W`, 6 — physical-register tag width
- `BM_W`, 4 — branch-mask width
- `clock` in 1 — sole clock
- `reset` in 1 — synchronous, active-high
- `issue_valid` in NUM_CH — channel issues this cycle
- `issue_tag` in NUM_CH×TAG_W — destination tag
- `issue_deadline` in NUM_CH×$clog2(MAX_LAT+1) — cycles allowed until CDB; 0 = same cycle
- `issue_bmask` in NUM_CH×BM_W — branch dependencies
- `cdb_valid` in N, `cdb_tag` in N×TAG_W — completing broadcasts
- `resolve_valid` in 1, `resolve_mask` in BM_W — branch resolved correctly
- `squash_valid` in 1, `squash_mask` in BM_W — mispredict
- `err_timeout`, `err_spurious`, `err_dup`, `err_overflow` out 1 each — sticky flags
- `first_err_code` out 3 — 0 none, 1 timeout, 2 spurious, 3 dup, 4 overflow
- `first_err_tag` out TAG_W — tag of first error
- `outstanding_cnt` out $clog2(DEPTH+1) — valid entries
- `completed_cnt` out 32 — matched completions, wraps

## Operation
- Entry: {valid, tag, age, deadline, bmask}. Every cycle, each valid entry's age increments by 1 and saturates at MAX_LAT+1.
- CDB match: each valid `cdb_valid` lane clears the valid entry with an equal tag. A same-cycle issue with deadline 0 and an equal tag is matched by bypass and never allocated. Each match increments `completed_cnt`.
- Deadline 0 with no same-cycle CDB match: timeout. No entry is allocated.
- Issue with deadline ≥ 1 and no same-cycle match: allocate the lowest free entries, in channel order 0→NUM_CH-1, with age 0.
- Duplicate: an issued tag equals a valid entry's tag, or another same-cycle issued tag. This sets `err_dup`. The later channel is not allocated.
- Spurious: a CDB tag matches neither an entry nor a same-cycle issue. This sets `err_spurious`.
- Timeout: when an entry's age exceeds its deadline before a match, set `err_timeout` and free the entry.
- Overflow: an issue finds no free entry. This sets `err_overflow` and the issue is dropped.
- Resolve: `resolve_mask` bits are cleared from every entry's bmask.
- Priority within a cycle: CDB match, then squash, then resolve, then timeout check, then allocation. A freed entry is reusable the next cycle, not the same cycle.
- `first_err_code`/`first_err_tag` latch the first error only. If several errors occur in one cycle, the lowest nonzero code wins; within a code, the lowest channel/lane/entry wins.

## Timing
- Detection happens in cycle t. Flags, counters and the table update register at the clock edge ending cycle t and are visible in t+1.
- `outstanding_cnt` reflects the post-update table.
- Reset: every table entry invalid. All flags, codes, tags and counters read 0 the cycle after reset is sampled high. Reset mid-operation discards in-flight entries without flagging them.
- Error flags stay high until reset.
- Full table with a simultaneous CDB match and issue: the issue overflows, because the freed slot is not reusable until the next cycle.

## Configuration
- `EXEC_MON_SQUASH_EN` defined: on `squash_valid`, entries with (bmask & squash_mask) ≠ 0 are invalidated without error. Same-cycle issues whose issue_bmask intersects squash_mask are ignored.
- `EXEC_MON_SQUASH_EN` undefined: `squash_valid`/`squash_mask` are ignored. Squashed instructions must still complete, or they time out.

## Test plan
- Issue tag 5, deadline 0 on ch0, CDB lane0 tag 5 same cycle → no flags, completed_cnt=1, outstanding_cnt=0.
- Issue tag 9, deadline 4 (mult); CDB tag 9 four cycles later → clean. Repeat with no CDB → err_timeout in the cycle after age 5, first_err_code=1, first_err_tag=9.
- CDB lane1 tag 12 with nothing outstanding → err_spurious next cycle, first_err_code=2.
- Issue tag 3 on ch0 and ch2 in the same cycle → err_dup, outstanding_cnt=1.
- DEPTH=16 entries held, then one more issue → err_overflow, outstanding_cnt stays 16.
- With EXEC_MON_SQUASH_EN: tags 7 (bmask 0010) and 8 (bmask 0001) outstanding, squash_mask 0010 → outstanding_cnt=1, no flags. Without the macro, tag 7 times out.
